// File: rtl/simple_bus_master_if.sv
// Signal bundle between a simple_bus requester (master) and the memory-side responder (slave).
// The clock is carried as a plain port on each side.
interface simple_bus_master_if;
    logic       req;
    logic       gnt;
    logic       start;
    logic       rdy;
    logic [7:0] addr;
    logic [1:0] mode;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    modport master (
        output req, start, addr, mode, data_out, data_oe,
        input  gnt, rdy, data_in
    );

    modport slave (
        input  req, start, addr, mode, data_out, data_oe,
        output gnt, rdy, data_in
    );
endinterface

// File: rtl/simple_bus_master.sv
// Queues client read/write commands and runs each on simple_bus with req/gnt/start/rdy,
// returning exactly one response (data or error) per command.
module simple_bus_master #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [7:0]          cmd_addr,
    input  logic [7:0]          cmd_wdata,
    output logic                rsp_valid,
    output logic [7:0]          rsp_data,
    output logic                rsp_err,
    output logic                busy,
    simple_bus_master_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;

    typedef enum logic [2:0] {IDLE, REQ, START, WAIT, RESP} state_t;

    logic [17:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full, push, pop;
    logic [1:0]    head_mode;
    logic [7:0]    head_addr, head_wdata;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [7:0]    addr_reg, addr_next;
    logic [1:0]    mode_reg, mode_next;
    logic [7:0]    wdata_reg, wdata_next;
    logic [7:0]    rdata_reg, rdata_next;
    logic          err_reg, err_next;
    logic          timer_done;

    // Readiness comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign full  = (count_reg == CW'(DEPTH));
    assign push  = cmd_valid && !full;
    assign pop   = (state_reg == RESP);
    assign count_next = count_reg + CW'(push) - CW'(pop);
    assign {head_mode, head_addr, head_wdata} = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_mode, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    assign timer_done = (timer_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            addr_reg  <= '0;
            mode_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            addr_reg  <= addr_next;
            mode_reg  <= mode_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        addr_next  = addr_reg;
        mode_next  = mode_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        unique case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    if (head_mode[1]) begin
                        state_next = RESP;
                        err_next   = 1'b1;
                    end else begin
                        state_next = REQ;
                        timer_next = '0;
                        addr_next  = head_addr;
                        mode_next  = head_mode;
                        wdata_next = head_wdata;
                    end
                end
            end
            REQ: begin
                timer_next = timer_reg + TW'(1);
                // A grant in the last allowed cycle beats the timeout.
                if (bus.gnt) begin
                    state_next = START;
                end else if (timer_done) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                    addr_next  = '0;
                    mode_next  = '0;
                    wdata_next = '0;
                end
            end
            START: begin
                state_next = WAIT;
                timer_next = '0;
            end
            WAIT: begin
                timer_next = timer_reg + TW'(1);
                if (bus.rdy) begin
                    state_next = RESP;
                    rdata_next = (mode_reg == MODE_READ) ? bus.data_in : 8'h00;
                    addr_next  = '0;
                    mode_next  = '0;
                    wdata_next = '0;
                end else if (timer_done) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                    addr_next  = '0;
                    mode_next  = '0;
                    wdata_next = '0;
                end
            end
            RESP: begin
                state_next = IDLE;
                timer_next = '0;
                rdata_next = 8'h00;
                err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready    = !full;
    assign busy         = (state_reg != IDLE) || (count_reg != '0);
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_err      = err_reg;
    assign rsp_data     = rdata_reg;

    assign bus.req      = (state_reg == REQ) || (state_reg == START) || (state_reg == WAIT);
    assign bus.start    = (state_reg == START);
    assign bus.addr     = addr_reg;
    assign bus.mode     = mode_reg;
    assign bus.data_out = wdata_reg;
    assign bus.data_oe  = ((state_reg == START) || (state_reg == WAIT)) && (mode_reg == MODE_WRITE);
endmodule
